// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR chain (fir_filter -> fir_decimator).
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Rounding arithmetic right shift: adds half an LSB of the result, then
  // shifts, so ties round toward +inf (round-half-up). sh == 0 is identity.
  function automatic logic signed [31:0] round_shift(input logic signed [31:0] v,
                                                     input int unsigned      sh);
    logic signed [31:0] half;
    if (sh == 0) begin
      return v;
    end
    half = 32'sd1 <<< (sh - 1);
    return (v + half) >>> sh;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO. Pop on empty and push on full are ignored, except
// that a push on full succeeds when a pop frees the slot in the same cycle.
// The head is forced to zero while empty so the output is clean after reset.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimate-by-2^LOG2_DECIM after fir_filter: rounded boxcar average of each
// group of D samples, delivered through an output FIFO with a sticky
// overflow flag when a result must be dropped.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     overflow
);

  localparam int D     = 1 << LOG2_DECIM;
  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum;
  logic [DATA_W-1:0]       result;
  logic                    last, push, pop, drop, full, empty;
  logic                    ovf_q, ovf_d;
  logic [DATA_W-1:0]       head;

  assign last   = (phase_q == PH_W'(D - 1));
  assign sum    = acc_q + ACC_W'(x_in);
  // Average of D samples of DATA_W bits always fits back in DATA_W.
  assign result = DATA_W'(round_shift(32'(sum), LOG2_DECIM));

  assign push = x_valid && last;
  assign pop  = m_valid && m_ready;
  // A full FIFO only loses the result if nothing leaves the same cycle.
  assign drop = push && full && !pop;

  // Phase/accumulator/overflow next state; phase only moves on valid samples.
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q || drop;
    if (x_valid) begin
      if (last) begin
        phase_d = '0;
        acc_d   = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
        acc_d   = sum;
      end
    end
  end

  // Group state; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (result),
    .full_o  (full),
    .empty_o (empty),
    .data_o  (head)
  );

  assign m_valid  = !empty;
  assign m_data   = head;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator (D = 4, FIFO depth 4). Inputs are driven
// and outputs sampled on the falling edge.
module tb_fir_decimator;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] x_in;
  logic               x_valid;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               overflow;

  int n_tests = 0;
  int n_fail  = 0;

  fir_decimator dut (
    .clk      (clk),
    .reset    (reset),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int v);
    x_in    = 16'(v);
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  // One group with m_ready = 1; g < 0 means back-to-back, else idle gaps
  // of (g+k)%6 cycles between samples.
  task automatic group(input string tag, input int a, input int b, input int c,
                       input int d, input int g, input int exp);
    int s[4];
    s = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check({tag, "_early"}, 32'(m_valid), 0);
      put(s[k]);
      if (k < 3 && g >= 0) idle((g + k) % 6);
    end
    check({tag, "_vld"}, 32'(m_valid), 1);
    check({tag, "_dat"}, 32'(m_data), exp);
    idle(1);
    check({tag, "_pop"}, 32'(m_valid), 0);
  endtask

  initial begin
    reset = 1'b0; x_valid = 1'b0; x_in = '0; m_ready = 1'b1;
    @(negedge clk);

    // 1: reset ignores valid samples
    x_valid = 1'b1; x_in = 16'sd500;
    repeat (3) @(negedge clk);
    check("rst_vld", 32'(m_valid), 0);
    check("rst_dat", 32'(m_data), 0);
    check("rst_ovf", 32'(overflow), 0);
    x_valid = 1'b0; reset = 1'b1;
    group("rel", 100, 100, 100, 100, -1, 100);

    // 2: steady stream, one-cycle output pulses
    for (int i = 1; i <= 8; i++) begin
      put(100);
      check($sformatf("stream_vld%0d", i), 32'(m_valid), (i == 4 || i == 8) ? 1 : 0);
      if (i == 4 || i == 8) check($sformatf("stream_dat%0d", i), 32'(m_data), 100);
    end
    idle(1);
    check("stream_end", 32'(m_valid), 0);

    // 3: rounding and extremes; FIR [1 2 1]/4 impulse response to 32767
    group("r111", 1, 1, 1, 0, -1, 1);
    group("rm11", -1, -1, 0, 0, -1, 0);
    group("rm3", -3, 0, 0, 0, -1, -1);
    group("rmax", 32767, 32767, 32767, 32767, -1, 32767);
    group("rmin", -32768, -32768, -32768, -32768, -1, -32768);
    group("rimp", 8191, 16383, 8191, 0, -1, 8191);

    // 4: same groups with irregular gaps
    group("g111", 1, 1, 1, 0, 0, 1);
    group("gm11", -1, -1, 0, 0, 1, 0);
    group("gm3", -3, 0, 0, 0, 2, -1);
    group("gmax", 32767, 32767, 32767, 32767, 3, 32767);
    group("gmin", -32768, -32768, -32768, -32768, 4, -32768);
    group("gimp", 8191, 16383, 8191, 0, 5, 8191);

    // 5a: backpressure, fifth result dropped
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      repeat (4) put(k);
      if (k == 4) check("bp_ovf_before", 32'(overflow), 0);
    end
    check("bp_ovf", 32'(overflow), 1);
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_vld%0d", k), 32'(m_valid), 1);
      check($sformatf("bp_dat%0d", k), 32'(m_data), k);
      @(negedge clk);
    end
    check("bp_empty", 32'(m_valid), 0);
    check("bp_ovf_sticky", 32'(overflow), 1);

    // 5b: push coinciding with pop on a full FIFO
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    check("clr_ovf", 32'(overflow), 0);
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) repeat (4) put(k);
    repeat (3) put(5);
    m_ready = 1'b1;
    put(5);
    m_ready = 1'b0;
    check("co_ovf", 32'(overflow), 0);
    m_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("co_dat%0d", k), 32'(m_data), k);
      @(negedge clk);
    end
    check("co_empty", 32'(m_valid), 0);

    // 6: reset mid-group discards partial sum
    put(1000); put(1000);
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    group("midrst", 8, 8, 8, 8, -1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
